// File: rtl/dual_cpu_bus_arbiter.sv
// Round-robin request/grant arbiter sharing one system bus between two rv32i cores.
// Optional transfer timeout enabled by defining ARB_TIMEOUT_EN.
module dual_cpu_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    input  logic        halt,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic [3:0]  s_be,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        grant_id,
    output logic        busy
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        s_valid_q, s_valid_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic        s_we_q, s_we_d;
    logic [3:0]  s_be_q, s_be_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic        busy_q, busy_d;
    logic        win;
`ifdef ARB_TIMEOUT_EN
    logic        m0_err_q, m0_err_d;
    logic        m1_err_q, m1_err_d;
    logic [15:0] cnt_q, cnt_d;
`endif

    // On contention the core that did not win last time gets the bus.
    assign win = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        s_valid_d    = s_valid_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_we_d       = s_we_q;
        s_be_d       = s_be_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!halt && (m0_req || m1_req)) begin
                    state_d      = XFER;
                    last_grant_d = win;
                    grant_id_d   = win;
                    s_valid_d    = 1'b1;
                    s_addr_d     = win ? m1_addr  : m0_addr;
                    s_wdata_d    = win ? m1_wdata : m0_wdata;
                    s_we_d       = win ? m1_we    : m0_we;
                    s_be_d       = win ? m1_be    : m0_be;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            XFER: begin
                if (s_ready) begin
                    state_d   = RESP;
                    s_valid_d = 1'b0;
                    if (grant_id_q) begin
                        m1_ready_d = 1'b1;
                        if (!s_we_q) m1_rdata_d = s_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        if (!s_we_q) m0_rdata_d = s_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Abort on the cycle the count would reach TIMEOUT; s_ready above takes priority.
                else if (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT)) begin
                    state_d   = RESP;
                    s_valid_d = 1'b0;
                    if (grant_id_q) begin
                        m1_ready_d = 1'b1;
                        m1_err_d   = 1'b1;
                        m1_rdata_d = '0;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_err_d   = 1'b1;
                        m0_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            s_valid_q    <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_we_q       <= 1'b0;
            s_be_q       <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            s_valid_q    <= s_valid_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_we_q       <= s_we_d;
            s_be_q       <= s_be_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
            cnt_q    <= cnt_d;
        end
    end
    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_we     = s_we_q;
    assign s_be     = s_be_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: doc/dual_cpu_bus_arbiter.md
# dual_cpu_bus_arbiter

Request/grant arbiter that shares the single system bus between the two rv32i cores and replaces the free-running per-cycle toggle. Each core issues a held request; the arbiter grants one core at a time (round-robin on contention), latches its command, drives the shared bus until the slave acknowledges, and returns read data with a one-cycle ready pulse. It sits between the two cores and the address decoder, and it provides a halt input for the PMU sleep path.

## Interface
- TIMEOUT, 255, cycles a granted transfer may wait for `s_ready` before abort (1..65535; used only with ARB_TIMEOUT_EN)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m0_req / m1_req  in  1  core requests transfer; held until its `mN_ready`
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_be / m1_be  in  4  byte enables
- m0_rdata / m1_rdata  out  32  registered read data, valid with `mN_ready`, held until that core's next response
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle abort flag, coincident with `mN_ready`
- halt  in  1  PMU sleep: blocks new grants
- s_valid  out  1  bus command valid
- s_addr, s_wdata  out  32  latched command address and data
- s_we  out  1  latched write enable
- s_be  out  4  latched byte enables
- s_rdata  in  32  slave read data, sampled when `s_ready`=1
- s_ready  in  1  slave acknowledge
- grant_id  out  1  current or last owner (0 = cpu0)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, XFER, RESP.
- IDLE: if `halt`=0 and any request is pending, pick a winner, latch its addr/wdata/we/be into the s_* registers, set `grant_id`, and go to XFER. Otherwise remain in IDLE.
- Winner rule: a single requester always wins. If both request, the winner is the core that is not `last_grant`. `last_grant` updates at every grant.
- XFER: `s_valid`=1 and the s_* signals stay stable. When `s_ready`=1, capture `s_rdata` into the owner's `mN_rdata` (capture on reads only; writes leave it unchanged) and go to RESP.
- RESP: the owner's `mN_ready`=1 for exactly one cycle, then the block returns to IDLE. The non-owner sees no pulse.
- A core drops `mN_req` or presents a new command in the cycle after its `mN_ready`. Changes to `mN_*` during XFER are ignored because the command is latched.
- `halt` during XFER or RESP does not stop the current transfer. The transfer completes, and the block then stays in IDLE while `halt`=1.
- Reset values: state=IDLE, `last_grant`=1 (cpu0 wins the first contention), `grant_id`=0. All s_* outputs, `m*_rdata`, `m*_ready`, `m*_err` and `busy` are 0.
- Reset asserted mid-transfer aborts it immediately, with no ready pulse to either core.

## Timing
- All outputs are registered. There are no combinational paths from `mN_*` to `s_*`.
- A request seen in IDLE at edge k drives `s_valid`=1 from cycle k+1.
- When `s_ready`=1 in cycle j, `mN_ready`=1 in cycle j+1.
- Zero-wait slave: 3 cycles per transfer (IDLE, XFER, RESP).
- Under continuous contention the two cores alternate grants. Each core gets one transfer per 6 cycles.
- `s_ready` is ignored outside XFER.

## Configuration
- ARB_TIMEOUT_EN defined:
  - a 16-bit counter clears on entry to XFER and increments each XFER cycle without `s_ready`.
  - When the count reaches TIMEOUT, the transfer aborts: go to RESP, deassert `s_valid`, set `mN_rdata`=32'h0, and pulse `mN_err`=1 together with `mN_ready`.
  - If `s_ready` arrives in the same cycle the count reaches TIMEOUT, the transfer completes normally with no error.
- ARB_TIMEOUT_EN undefined:
  - XFER waits indefinitely, `m*_err` is tied to 0, and no counter is synthesised.

## Test plan
- Single read: cpu0 reads addr 0x0000_0010, slave returns 0xA5A5_1234 with zero wait -> `s_valid` high 1 cycle, `m0_ready` 1 cycle later, `m0_rdata`=0xA5A5_1234, `m1_ready` stays 0.
- Contention after reset: both request in the same cycle -> cpu0 granted first, then cpu1. Continuous requests -> grants alternate 0,1,0,1 at a 3-cycle spacing.
- Wait states: slave holds `s_ready` low for 5 cycles on a write of 0xDEAD_BEEF to 0x1000_1004 with be=4'hF -> s_* stable for all 6 XFER cycles, then one `m1_ready` pulse.
- Halt: `halt` raised during cpu0's XFER -> cpu0 completes. A pending cpu1 request is not granted until `halt` falls, and is granted 1 cycle after.
- Reset mid-XFER: `rst` pulsed while `s_valid`=1 -> all outputs 0 asynchronously and no ready pulse. The first post-reset contention goes to cpu0.
- With ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready -> `m0_err`=`m0_ready`=1, `m0_rdata`=0 on the cycle after the 8th XFER cycle, and the block returns to IDLE.
